// File: rtl/pcd8544_rx_if.sv
// Serial link from the screen controller plus the decoded strobe/bus outputs.
`timescale 1ns/1ps
interface pcd8544_rx_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              lcd_sck;
    logic              lcd_sdin;
    logic              lcd_sce_n;
    logic              lcd_dc;
    logic              lcd_res_n;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              cmd_stb;
    logic [7:0]        cmd_byte;

    // Controller side: drives the LCD pins, observes the decoded results
    modport master (
        output lcd_sck, lcd_sdin, lcd_sce_n, lcd_dc, lcd_res_n,
        input  mem_we, mem_addr, mem_data, cmd_stb, cmd_byte
    );

    // Receiver side: samples the LCD pins, produces RAM writes and command strobes
    modport slave (
        input  lcd_sck, lcd_sdin, lcd_sce_n, lcd_dc, lcd_res_n,
        output mem_we, mem_addr, mem_data, cmd_stb, cmd_byte
    );
endinterface

// File: rtl/pcd8544_rx.sv
// PCD8544 serial receiver: oversamples the LCD pins, assembles bytes, mirrors
// the LCD command state and turns data bytes into auto-incrementing RAM writes.
`timescale 1ns/1ps
module pcd8544_rx #(
    parameter int unsigned COLS   = 84,
    parameter int unsigned ROWS   = 6,
    parameter int unsigned ADDR_W = 9
) (
    input  logic       clk,
    input  logic       reset,
    pcd8544_rx_if.slave bus,
    output logic       pd,
    output logic       v,
    output logic       h,
    output logic [1:0] disp_mode,
    output logic [6:0] vop,
    output logic [2:0] bias,
    output logic [1:0] tc,
    output logic [6:0] cur_x,
    output logic [2:0] cur_y
);
    localparam int unsigned X_W   = 7;
    localparam int unsigned Y_W   = 3;
    localparam int unsigned CNT_W = 3;
    localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

    logic [1:0] sck_sync, sdin_sync, sce_sync, dc_sync, res_sync;
    logic       sck_prev;
    logic       sck_s, sdin_s, sce_n_s, dc_s, res_n_s;
    logic       sck_rise_c;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] rx_byte_c;
    logic [ADDR_W-1:0] addr_c;
    logic [X_W-1:0] next_x_c;
    logic [Y_W-1:0] next_y_c;
    logic       y_ok_c, x_ok_c;

    assign sck_s   = sck_sync[1];
    assign sdin_s  = sdin_sync[1];
    assign sce_n_s = sce_sync[1];
    assign dc_s    = dc_sync[1];
    assign res_n_s = res_sync[1];

    assign sck_rise_c = sck_s & ~sck_prev;
    assign rx_byte_c  = {shreg[6:0], sdin_s};
    assign addr_c     = ADDR_W'(cur_y) * ADDR_W'(COLS) + ADDR_W'(cur_x);
    assign y_ok_c     = {29'd0, rx_byte_c[2:0]} < ROWS;
    assign x_ok_c     = {25'd0, rx_byte_c[6:0]} < COLS;

    // Two-flop synchronisers for the asynchronous LCD pins plus SCK edge history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= 2'b00;
            sdin_sync <= 2'b00;
            sce_sync  <= 2'b11;
            dc_sync   <= 2'b00;
            res_sync  <= 2'b11;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0],  bus.lcd_sck};
            sdin_sync <= {sdin_sync[0], bus.lcd_sdin};
            sce_sync  <= {sce_sync[0],  bus.lcd_sce_n};
            dc_sync   <= {dc_sync[0],   bus.lcd_dc};
            res_sync  <= {res_sync[0],  bus.lcd_res_n};
            sck_prev  <= sck_s;
        end
    end

    // Address auto-increment: horizontal walks X then Y, vertical walks Y then X
    always_comb begin
        next_x_c = cur_x;
        next_y_c = cur_y;
        if (!v) begin
            if (cur_x == X_LAST) begin
                next_x_c = '0;
                next_y_c = (cur_y == Y_LAST) ? '0 : cur_y + Y_W'(1);
            end else begin
                next_x_c = cur_x + X_W'(1);
            end
        end else begin
            if (cur_y == Y_LAST) begin
                next_y_c = '0;
                next_x_c = (cur_x == X_LAST) ? '0 : cur_x + X_W'(1);
            end else begin
                next_y_c = cur_y + Y_W'(1);
            end
        end
    end

    // Byte assembly, command decode and display-RAM write generation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pd           <= 1'b1;
            v            <= 1'b0;
            h            <= 1'b0;
            disp_mode    <= 2'd0;
            vop          <= 7'd0;
            bias         <= 3'd0;
            tc           <= 2'd0;
            cur_x        <= '0;
            cur_y        <= '0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= 8'd0;
            bus.cmd_stb  <= 1'b0;
            bus.cmd_byte <= 8'd0;
            bit_cnt      <= '0;
            shreg        <= 8'd0;
        end else begin
            bus.mem_we  <= 1'b0;
            bus.cmd_stb <= 1'b0;
            if (!res_n_s) begin
                // LCD soft reset: same state as the hard reset, partial byte dropped
                pd           <= 1'b1;
                v            <= 1'b0;
                h            <= 1'b0;
                disp_mode    <= 2'd0;
                vop          <= 7'd0;
                bias         <= 3'd0;
                tc           <= 2'd0;
                cur_x        <= '0;
                cur_y        <= '0;
                bus.mem_addr <= '0;
                bus.mem_data <= 8'd0;
                bus.cmd_byte <= 8'd0;
                bit_cnt      <= '0;
                shreg        <= 8'd0;
            end else if (sce_n_s) begin
                bit_cnt <= '0;
                shreg   <= 8'd0;
            end else if (sck_rise_c) begin
                shreg <= rx_byte_c;
                if (bit_cnt == CNT_W'(7)) begin
                    bit_cnt <= '0;
                    if (dc_s) begin
                        bus.mem_we   <= 1'b1;
                        bus.mem_addr <= addr_c;
                        bus.mem_data <= rx_byte_c;
                        cur_x        <= next_x_c;
                        cur_y        <= next_y_c;
                    end else begin
                        bus.cmd_stb  <= 1'b1;
                        bus.cmd_byte <= rx_byte_c;
                        if (rx_byte_c[7:3] == 5'b00100) begin
                            pd <= rx_byte_c[2];
                            v  <= rx_byte_c[1];
                            h  <= rx_byte_c[0];
                        end else if (!h) begin
                            if (rx_byte_c[7:3] == 5'b00001) begin
                                disp_mode <= {rx_byte_c[2], rx_byte_c[0]};
                            end else if (rx_byte_c[7:3] == 5'b01000) begin
                                if (y_ok_c) begin
                                    cur_y <= rx_byte_c[2:0];
                                end
                            end else if (rx_byte_c[7]) begin
                                if (x_ok_c) begin
                                    cur_x <= rx_byte_c[6:0];
                                end
                            end
                        end else begin
                            if (rx_byte_c[7:2] == 6'b000001) begin
                                tc <= rx_byte_c[1:0];
                            end else if (rx_byte_c[7:3] == 5'b00010) begin
                                bias <= rx_byte_c[2:0];
                            end else if (rx_byte_c[7]) begin
                                vop <= rx_byte_c[6:0];
                            end
                        end
                    end
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_pcd8544_rx.sv
// Bench for pcd8544_rx: directed and random serial traffic, a scoreboard of
// expected strobes, and a reference model of the LCD state.
`timescale 1ns/1ps
module tb_pcd8544_rx;
    localparam int COLS = 84;
    localparam int ROWS = 6;

    logic clk = 1'b0;
    logic reset;
    logic pd, v, h;
    logic [1:0] disp_mode;
    logic [6:0] vop;
    logic [2:0] bias;
    logic [1:0] tc;
    logic [6:0] cur_x;
    logic [2:0] cur_y;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       is_data;
        logic [8:0] addr;
        logic [7:0] val;
    } ev_t;
    ev_t exp_q[$];

    int m_pd, m_v, m_h, m_dm, m_vop, m_bias, m_tc, m_x, m_y;

    always #5 clk = ~clk;

    pcd8544_rx_if #(.ADDR_W(9)) bus ();

    pcd8544_rx #(.COLS(84), .ROWS(6), .ADDR_W(9)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .pd        (pd),
        .v         (v),
        .h         (h),
        .disp_mode (disp_mode),
        .vop       (vop),
        .bias      (bias),
        .tc        (tc),
        .cur_x     (cur_x),
        .cur_y     (cur_y)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pd = 1; m_v = 0; m_h = 0; m_dm = 0; m_vop = 0;
        m_bias = 0; m_tc = 0; m_x = 0; m_y = 0;
    endfunction

    // Reference behaviour: linear/column-major indices for auto-increment
    function automatic void model_byte(input logic [7:0] b, input logic d);
        ev_t e;
        int  bi = int'(b);
        int  idx;
        e.is_data = d;
        e.val     = b;
        e.addr    = d ? 9'(m_y * COLS + m_x) : 9'd0;
        exp_q.push_back(e);
        if (d) begin
            if (m_v == 0) begin
                idx = (m_y * COLS + m_x + 1) % (COLS * ROWS);
                m_x = idx % COLS;
                m_y = idx / COLS;
            end else begin
                idx = (m_x * ROWS + m_y + 1) % (COLS * ROWS);
                m_x = idx / ROWS;
                m_y = idx % ROWS;
            end
        end else if (bi >= 'h20 && bi <= 'h27) begin
            m_pd = (bi >> 2) & 1;
            m_v  = (bi >> 1) & 1;
            m_h  = bi & 1;
        end else if (m_h == 0) begin
            if (bi >= 'h08 && bi <= 'h0F) m_dm = ((bi >> 2) & 1) * 2 + (bi & 1);
            else if (bi >= 'h40 && bi <= 'h47) begin
                if (bi - 'h40 < ROWS) m_y = bi - 'h40;
            end else if (bi >= 'h80) begin
                if (bi - 'h80 < COLS) m_x = bi - 'h80;
            end
        end else begin
            if (bi >= 'h04 && bi <= 'h07) m_tc = bi - 'h04;
            else if (bi >= 'h10 && bi <= 'h17) m_bias = bi - 'h10;
            else if (bi >= 'h80) m_vop = bi - 'h80;
        end
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.lcd_sck  = 1'b0;
            bus.lcd_sdin = b[7-i];
            wait_clk(4);
            bus.lcd_sck = 1'b1;
            wait_clk(4);
        end
        bus.lcd_sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d);
        bus.lcd_dc    = d;
        bus.lcd_sce_n = 1'b0;
        model_byte(b, d);
        shift_bits(b, 8);
        wait_clk(3);
    endtask

    task automatic deselect();
        bus.lcd_sce_n = 1'b1;
        bus.lcd_sck   = 1'b0;
        wait_clk(5);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pd"},   int'(pd),        m_pd);
        chk({tag, ".v"},    int'(v),         m_v);
        chk({tag, ".h"},    int'(h),         m_h);
        chk({tag, ".dm"},   int'(disp_mode), m_dm);
        chk({tag, ".vop"},  int'(vop),       m_vop);
        chk({tag, ".bias"}, int'(bias),      m_bias);
        chk({tag, ".tc"},   int'(tc),        m_tc);
        chk({tag, ".x"},    int'(cur_x),     m_x);
        chk({tag, ".y"},    int'(cur_y),     m_y);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".pd"},       int'(pd), 1);
        chk({tag, ".v"},        int'(v), 0);
        chk({tag, ".h"},        int'(h), 0);
        chk({tag, ".dm"},       int'(disp_mode), 0);
        chk({tag, ".vop"},      int'(vop), 0);
        chk({tag, ".bias"},     int'(bias), 0);
        chk({tag, ".tc"},       int'(tc), 0);
        chk({tag, ".x"},        int'(cur_x), 0);
        chk({tag, ".y"},        int'(cur_y), 0);
        chk({tag, ".mem_we"},   int'(bus.mem_we), 0);
        chk({tag, ".mem_addr"}, int'(bus.mem_addr), 0);
        chk({tag, ".mem_data"}, int'(bus.mem_data), 0);
        chk({tag, ".cmd_stb"},  int'(bus.cmd_stb), 0);
        chk({tag, ".cmd_byte"}, int'(bus.cmd_byte), 0);
    endtask

    task automatic hard_reset();
        reset = 1'b1;
        bus.lcd_sck = 1'b0;
        wait_clk(3);
        model_reset();
        reset = 1'b0;
        wait_clk(3);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected event
    always @(negedge clk) begin
        ev_t e;
        if (!reset && (bus.mem_we || bus.cmd_stb)) begin
            if (bus.mem_we && bus.cmd_stb)
                chk("both_strobes", 1, 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual=we%0d/stb%0d expected=none at %0t",
                         bus.mem_we, bus.cmd_stb, $time);
            end else begin
                e = exp_q.pop_front();
                if (e.is_data) begin
                    chk("kind_data", int'(bus.mem_we), 1);
                    chk("mem_addr",  int'(bus.mem_addr), int'(e.addr));
                    chk("mem_data",  int'(bus.mem_data), int'(e.val));
                end else begin
                    chk("kind_cmd", int'(bus.cmd_stb), 1);
                    chk("cmd_byte", int'(bus.cmd_byte), int'(e.val));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cmds [6];
        logic [7:0] rb;
        logic       rd;
        cmds[0] = 8'h21; cmds[1] = 8'hBF; cmds[2] = 8'h04;
        cmds[3] = 8'h14; cmds[4] = 8'h20; cmds[5] = 8'h0C;

        reset         = 1'b1;
        bus.lcd_sck   = 1'b0;
        bus.lcd_sdin  = 1'b0;
        bus.lcd_sce_n = 1'b1;
        bus.lcd_dc    = 1'b0;
        bus.lcd_res_n = 1'b1;
        model_reset();
        wait_clk(4);
        reset = 1'b0;
        wait_clk(3);
        check_reset_outputs("rst");

        // Initialisation command sequence
        foreach (cmds[i]) send_byte(cmds[i], 1'b0);
        chk("init.h", int'(h), 0);
        chk("init.vop", int'(vop), 'h3F);
        chk("init.tc", int'(tc), 0);
        chk("init.bias", int'(bias), 4);
        chk("init.dm", int'(disp_mode), 2);
        chk("init.pd", int'(pd), 0);
        check_state("init");

        // First data byte after reset
        hard_reset();
        send_byte(8'hAA, 1'b1);
        chk("data0.x", int'(cur_x), 1);
        check_state("data0");

        // Last cell then full wrap
        send_byte(8'hD3, 1'b0);
        send_byte(8'h45, 1'b0);
        send_byte(8'h55, 1'b1);
        chk("wrap.x", int'(cur_x), 0);
        chk("wrap.y", int'(cur_y), 0);
        check_state("wrap");

        // Vertical addressing from origin
        hard_reset();
        send_byte(8'h22, 1'b0);
        for (int i = 0; i < 7; i++) send_byte(8'(8'h10 + i), 1'b1);
        chk("vert.x", int'(cur_x), 1);
        chk("vert.y", int'(cur_y), 1);
        check_state("vert");

        // Partial byte discarded on deselect
        send_byte(8'h20, 1'b0);
        bus.lcd_dc = 1'b0;
        bus.lcd_sce_n = 1'b0;
        shift_bits(8'hF0, 5);
        deselect();
        send_byte(8'h81, 1'b0);
        chk("partial.x", int'(cur_x), 1);
        check_state("partial");

        // Out-of-range X/Y ignored
        send_byte(8'hD4, 1'b0);
        send_byte(8'h46, 1'b0);
        chk("oor.x", int'(cur_x), 1);
        check_state("oor");

        // Hard reset in the middle of a byte
        send_byte(8'h25, 1'b0);
        bus.lcd_dc = 1'b1;
        shift_bits(8'hC3, 4);
        reset = 1'b1;
        wait_clk(2);
        check_reset_outputs("hrst_mid");
        model_reset();
        reset = 1'b0;
        wait_clk(3);
        send_byte(8'h3C, 1'b1);
        check_state("hrst_after");

        // LCD soft reset in the middle of a byte, chip still selected
        send_byte(8'h9A, 1'b0);
        bus.lcd_dc = 1'b1;
        shift_bits(8'h5A, 3);
        bus.lcd_res_n = 1'b0;
        wait_clk(5);
        check_reset_outputs("srst_mid");
        model_reset();
        bus.lcd_res_n = 1'b1;
        wait_clk(4);
        send_byte(8'h77, 1'b1);
        check_state("srst_after");

        // Random traffic against the reference model
        for (int n = 0; n < 200; n++) begin
            rd = 1'($urandom_range(0, 1));
            rb = 8'($urandom_range(0, 255));
            if (!rd && $urandom_range(0, 3) == 0) rb = 8'(8'h20 + $urandom_range(0, 7));
            send_byte(rb, rd);
            if ($urandom_range(0, 9) == 0) deselect();
            check_state("rand");
        end

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) wait_clk(1);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
